// File: rtl/button_debounce_multi.sv
// Purpose: synchronise and debounce NUM_BTNS raw buttons; emit clean level plus press/release/repeat pulses.
// Latency: raw change sampled at edge k shows on btn_level and press/release pulses after edge k+DEBOUNCE_CYCLES+1.
// Backpressure: none; every output is a free-running registered level or single-cycle pulse.
module button_debounce_multi #(
    parameter int NUM_BTNS        = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] press_pulse,
    output logic [NUM_BTNS-1:0] release_pulse,
    output logic [NUM_BTNS-1:0] repeat_pulse,
    output logic                press_any
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW   = (RMAX < 1) ? 1 : $clog2(RMAX + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] HOLD_LAST = (HOLD_CYCLES > 0)   ? RW'(HOLD_CYCLES - 1)   : '0;
    localparam logic [RW-1:0] REP_LAST  = (REPEAT_CYCLES > 0) ? RW'(REPEAT_CYCLES - 1) : '0;
    localparam bit            REP_EN    = (HOLD_CYCLES > 0);
    localparam bit            REP_MULTI = (REPEAT_CYCLES > 0);

    // Sync flops reset to the raw value that means "not pressed" so reset never fakes a press.
    localparam logic [NUM_BTNS-1:0] INACTIVE = {NUM_BTNS{ACTIVE_LOW}};

    // WAIT_REL: single long-press pulse already given, hold quiet until release.
    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEATING,
        WAIT_REL
    } rep_state_t;

    logic [NUM_BTNS-1:0] sync_a;
    logic [NUM_BTNS-1:0] sync_b;
    logic [NUM_BTNS-1:0] s;
    logic [NUM_BTNS-1:0] level_nxt;
    logic [NUM_BTNS-1:0] press_acc;
    logic [NUM_BTNS-1:0] rel_acc;
    logic [NUM_BTNS-1:0] rep_fire;
    logic [DW-1:0]       dcnt     [NUM_BTNS];
    logic [DW-1:0]       dcnt_nxt [NUM_BTNS];
    logic [RW-1:0]       rcnt     [NUM_BTNS];
    logic [RW-1:0]       rcnt_nxt [NUM_BTNS];
    rep_state_t          state     [NUM_BTNS];
    rep_state_t          state_nxt [NUM_BTNS];

    // Two-flop synchroniser per channel; polarity fixed up after the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= INACTIVE;
            sync_b <= INACTIVE;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    assign s = sync_b ^ INACTIVE;

    // Debounce: count consecutive cycles that disagree with the accepted level; any agreement restarts.
    always_comb begin
        for (int i = 0; i < NUM_BTNS; i++) begin
            dcnt_nxt[i]  = '0;
            level_nxt[i] = btn_level[i];
            press_acc[i] = 1'b0;
            rel_acc[i]   = 1'b0;
            if (s[i] != btn_level[i]) begin
                if (dcnt[i] == DEB_LAST) begin
                    level_nxt[i] = s[i];
                    press_acc[i] = s[i];
                    rel_acc[i]   = ~s[i];
                end else begin
                    dcnt_nxt[i] = dcnt[i] + 1'b1;
                end
            end
        end
    end

    // Repeat FSM next-state: release wins over a repeat falling due in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_BTNS; i++) begin
            state_nxt[i] = state[i];
            rcnt_nxt[i]  = rcnt[i];
            rep_fire[i]  = 1'b0;
            if (!REP_EN || rel_acc[i]) begin
                state_nxt[i] = IDLE;
                rcnt_nxt[i]  = '0;
            end else begin
                case (state[i])
                    IDLE: begin
                        if (press_acc[i]) begin
                            state_nxt[i] = HELD;
                            rcnt_nxt[i]  = '0;
                        end
                    end
                    HELD: begin
                        if (rcnt[i] == HOLD_LAST) begin
                            rep_fire[i]  = 1'b1;
                            rcnt_nxt[i]  = '0;
                            state_nxt[i] = REP_MULTI ? REPEATING : WAIT_REL;
                        end else begin
                            rcnt_nxt[i] = rcnt[i] + 1'b1;
                        end
                    end
                    REPEATING: begin
                        if (rcnt[i] == REP_LAST) begin
                            rep_fire[i] = 1'b1;
                            rcnt_nxt[i] = '0;
                        end else begin
                            rcnt_nxt[i] = rcnt[i] + 1'b1;
                        end
                    end
                    WAIT_REL: begin
                        rcnt_nxt[i] = '0;
                    end
                    default: begin
                        state_nxt[i] = IDLE;
                        rcnt_nxt[i]  = '0;
                    end
                endcase
            end
        end
    end

    // Per-channel state registers: debounce counter and repeat FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                dcnt[i]  <= '0;
                rcnt[i]  <= '0;
                state[i] <= IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                dcnt[i]  <= dcnt_nxt[i];
                rcnt[i]  <= rcnt_nxt[i];
                state[i] <= state_nxt[i];
            end
        end
    end

    // Registered outputs; press_any shares the cycle of press_pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            repeat_pulse  <= '0;
            press_any     <= 1'b0;
        end else begin
            btn_level     <= level_nxt;
            press_pulse   <= press_acc;
            release_pulse <= rel_acc;
            repeat_pulse  <= rep_fire;
            press_any     <= |press_acc;
        end
    end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Purpose: directed vector bench for button_debounce_multi (2 channels, debounce 4, hold 10, repeat 3).
// Latency: inputs driven #1 after an edge, outputs sampled #1 after the following edge.
// Backpressure: not applicable.
module tb_button_debounce_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn_raw;
    logic [1:0] btn_level, press_pulse, release_pulse, repeat_pulse;
    logic       press_any;

    logic [1:0] raw_al;
    logic [1:0] al_level, al_press, al_release, al_repeat;
    logic       al_any;

    int passed = 0;
    int total  = 0;
    int cur    = 0;

    typedef struct {
        logic [1:0] raw;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
        logic [1:0] rep;
        logic       any;
    } vec_t;

    vec_t vecs[$];

    button_debounce_multi #(
        .NUM_BTNS(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .ACTIVE_LOW(1'b0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse), .press_any(press_any)
    );

    button_debounce_multi #(
        .NUM_BTNS(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .ACTIVE_LOW(1'b1)
    ) u_dut_al (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw_al),
        .btn_level(al_level), .press_pulse(al_press), .release_pulse(al_release),
        .repeat_pulse(al_repeat), .press_any(al_any)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic add(input int n, input logic [1:0] raw, input logic [1:0] lvl, input logic [1:0] prs,
                       input logic [1:0] rel, input logic [1:0] rep, input logic any);
        vec_t v;
        v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel; v.rep = rep; v.any = any;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at step %0d: got %b, expected %b", name, cur, act, exp);
    endtask

    task automatic check_all(input logic [1:0] lvl, input logic [1:0] prs, input logic [1:0] rel,
                             input logic [1:0] rep, input logic any);
        chk("btn_level", btn_level, lvl);
        chk("press_pulse", press_pulse, prs);
        chk("release_pulse", release_pulse, rel);
        chk("repeat_pulse", repeat_pulse, rep);
        chk("press_any", {1'b0, press_any}, {1'b0, any});
    endtask

    task automatic step(input logic [1:0] r);
        btn_raw = r;
        @(posedge clk);
        #1;
        cur++;
    endtask

    initial begin
        int p;

        // Steps count edges after reset release; raw given at step k is sampled on edge k.
        add(5, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        add(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1);
        add(5, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        add(1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        add(5, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        add(1, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 1'b1);
        add(5, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
        add(1, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 1'b1);
        add(5, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        add(1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        add(1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        add(2, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        add(5, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        add(1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1);
        add(1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        add(5, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        add(1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

        // Reset with both buttons held: outputs stay inactive.
        rst_n   = 1'b0;
        btn_raw = 2'b11;
        raw_al  = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check_all(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        chk("al_level in reset", al_level, 2'b00);
        rst_n = 1'b1;
        cur   = 0;

        // Table: held-through-reset press, clean release, simultaneous press/release, bounce.
        foreach (vecs[i]) begin
            step(vecs[i].raw);
            check_all(vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].rep, vecs[i].any);
            chk("al_level idle", al_level, 2'b00);
        end

        // Auto-repeat on ch1; release lands on a cycle where a repeat would be due.
        cur = 0;
        p   = -1;
        for (int n = 0; n < 20 && p < 0; n++) begin
            step(2'b10);
            if (press_pulse[1]) p = cur;
        end
        total++;
        if (p == 6) passed++;
        else $display("FAIL repeat press latency: got step %0d, expected step 6", p);
        for (int d = 1; d <= 32; d++) begin
            step((d >= 23) ? 2'b00 : 2'b10);
            check_all((d < 28) ? 2'b10 : 2'b00, 2'b00, (d == 28) ? 2'b10 : 2'b00,
                      (d >= 10 && d < 28 && (d - 10) % 3 == 0) ? 2'b10 : 2'b00, 1'b0);
        end

        // Mid-operation reset while ch0 is repeating.
        cur = 0;
        for (int n = 1; n <= 17; n++) begin
            step(2'b01);
            check_all((n >= 6) ? 2'b01 : 2'b00, (n == 6) ? 2'b01 : 2'b00, 2'b00,
                      (n == 16) ? 2'b01 : 2'b00, n == 6);
        end
        #2 rst_n = 1'b0;
        #1;
        check_all(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        check_all(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;
        cur   = 0;
        for (int n = 1; n <= 7; n++) begin
            step(2'b01);
            check_all((n >= 6) ? 2'b01 : 2'b00, (n == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00, n == 6);
        end
        cur = 0;
        for (int n = 1; n <= 6; n++) begin
            step(2'b00);
            check_all((n < 6) ? 2'b01 : 2'b00, 2'b00, (n == 6) ? 2'b01 : 2'b00, 2'b00, 1'b0);
        end

        // Active-low instance: raw ch0 falling to 0 is a press.
        cur    = 0;
        raw_al = 2'b10;
        for (int n = 1; n <= 7; n++) begin
            step(2'b00);
            chk("al_level", al_level, (n >= 6) ? 2'b01 : 2'b00);
            chk("al_press", al_press, (n == 6) ? 2'b01 : 2'b00);
            chk("al_release", al_release, 2'b00);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
